// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. One line transfer is
// outstanding at a time on the backing-memory port; hit/miss counters saturate.
module data_cache #(
    parameter int LINES       = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_input_valid,
    input  logic [31:0]               addr,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [31:0]               din,
    output logic                      is_ready,
    output logic                      is_output_valid,
    output logic                      is_hit,
    output logic [31:0]               dout,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [31:0]               mem_req_addr,
    output logic [32*BLOCK_WORDS-1:0] mem_req_wdata,
    input  logic                      mem_resp_valid,
    input  logic [32*BLOCK_WORDS-1:0] mem_resp_rdata,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count,
    output logic [1:0]                state
);
    localparam int WOFF_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int LINE_W = 32 * BLOCK_WORDS;
    localparam int BOFF_W = $clog2(LINE_W);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    // Memory handshake: a request transfers on a rising edge with
    // mem_req_valid & mem_req_ready, and mem_req_valid stays high until then.
    // mem_resp_valid is accepted only once the request phase has closed or is
    // closing in that same cycle; it is ignored in IDLE.

    logic [1:0]        state_q, state_d;
    logic              req_done_q;
    logic              retry_q;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WOFF_W-1:0] req_woff;
    logic [BOFF_W-1:0] bit_off;
    logic              request;
    logic              hit;
    logic              resp_accept;
    logic              idle_hit;
    logic              idle_miss;
    logic              fill_done;
    logic              unused_addr;

    assign req_tag     = addr[31 -: TAG_W];
    assign req_idx     = addr[OFF_W +: IDX_W];
    assign req_woff    = addr[2 +: WOFF_W];
    assign bit_off     = {req_woff, 5'b00000};
    assign unused_addr = ^addr[1:0];

    assign request     = is_input_valid & (mem_read | mem_write);
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign resp_accept = (req_done_q | mem_req_ready) & mem_resp_valid;
    assign idle_hit    = (state_q == S_IDLE) && request && hit;
    assign idle_miss   = (state_q == S_IDLE) && request && !hit;
    assign fill_done   = (state_q == S_ALLOCATE) && resp_accept;

    assign dout          = data_q[req_idx][bit_off +: 32];
    assign mem_req_wdata = data_q[req_idx];
    assign state         = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_done_q <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                req_done_q <= 1'b0;
            end else if (mem_req_valid && mem_req_ready) begin
                req_done_q <= 1'b1;
            end
            // The cycle after a fill is the replay of the stalled request.
            retry_q <= (state_q == S_ALLOCATE) && (state_d == S_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (request && !hit) begin
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (resp_accept) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (resp_accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        is_hit          = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_we      = 1'b0;
        mem_req_addr    = {req_tag, req_idx, {OFF_W{1'b0}}};
        case (state_q)
            S_IDLE: begin
                is_ready        = 1'b1;
                is_output_valid = !request || hit;
                is_hit          = !request || hit;
            end
            S_WRITEBACK: begin
                mem_req_valid = !req_done_q;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
            end
            S_ALLOCATE: begin
                mem_req_valid = !req_done_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (idle_hit) begin
                if (mem_write) dirty_q[req_idx] <= 1'b1;
                if (!retry_q && (hit_count != '1)) hit_count <= hit_count + 32'd1;
            end
            if (idle_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
            if (fill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
                tag_q[req_idx]   <= req_tag;
            end
        end
    end

    // Data array carries no reset; writes are held off while reset is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (idle_hit && mem_write) data_q[req_idx][bit_off +: 32] <= din;
            if (fill_done) data_q[req_idx] <= mem_resp_rdata;
        end
    end
endmodule
